// File: rtl/key_event_ctrl.sv
// Avalon-MM push-button controller: synchronise, debounce, detect edges,
// arbitrate key events into a pop-on-read FIFO with an optional level irq.
module key_event_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic [3:0]  in_port
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic [3:0]       sync_p0, sync_p1, deb, pending, dir;
  logic [CNT_W-1:0] cnt [4];
  logic             irq_en, rel_en, overflow;
  logic [2:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level, level_next;

  logic [3:0]  flip, deb_next, edge_set, grant;
  logic [1:0]  grant_idx;
  logic        grant_vld, pop, push, drop, ctrl_wr, status_wr, irq_en_next;
  logic [31:0] rd_mux;
  logic        wdata_unused;

  assign wdata_unused = ^{writedata[31:9], writedata[7:2]};

  // Debounce decision and edge capture; releases are filtered by rel_en.
  always_comb begin
    flip     = '0;
    deb_next = deb;
    for (int k = 0; k < 4; k++) begin
      if (sync_p1[k] != deb[k] && cnt[k] == CNT_MAX) begin
        flip[k]     = 1'b1;
        deb_next[k] = sync_p1[k];
      end
    end
    edge_set = flip & (deb_next | {4{rel_en}});
  end

  // Fixed priority: lowest key index wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int k = 3; k >= 0; k--) begin
      if (pending[k]) begin
        grant     = '0;
        grant[k]  = 1'b1;
        grant_idx = 2'(k);
      end
    end
  end

  assign grant_vld   = |pending;
  assign pop         = read && (address == 2'd1) && (level != '0);
  assign push        = grant_vld && ((level != LVL_FULL) || pop);
  assign drop        = grant_vld && !push;
  assign ctrl_wr     = write && (address == 2'd2);
  assign status_wr   = write && (address == 2'd3);
  assign irq_en_next = ctrl_wr ? writedata[0] : irq_en;
  assign level_next  = level + LVL_W'(push) - LVL_W'(pop);

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0: rd_mux[3:0] = deb;
      2'd1: begin
        if (level != '0) begin
          rd_mux[31]  = 1'b1;
          rd_mux[2:0] = mem[rd_ptr];
        end
      end
      2'd2: rd_mux[1:0] = {rel_en, irq_en};
      default: begin
        rd_mux[4:0] = 5'(level);
        rd_mux[8]   = overflow;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      deb      <= '0;
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
      pending  <= '0;
      dir      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      irq_en   <= 1'b0;
      rel_en   <= 1'b0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      sync_p0 <= ~in_port;
      sync_p1 <= sync_p0;
      deb     <= deb_next;
      for (int k = 0; k < 4; k++) begin
        if (sync_p1[k] == deb[k] || flip[k]) cnt[k] <= '0;
        else                                 cnt[k] <= cnt[k] + CNT_W'(1);
        if (edge_set[k]) dir[k] <= deb_next[k];
      end
      // A fresh edge re-arms a key even in the cycle its old event is granted.
      pending <= (pending & ~grant) | edge_set;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_next;
      if (drop)                           overflow <= 1'b1;
      else if (status_wr && writedata[8]) overflow <= 1'b0;
      if (ctrl_wr) begin
        irq_en <= writedata[0];
        rel_en <= writedata[1];
      end
      if (read) readdata <= rd_mux;
      irq <= irq_en_next && (level_next != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {dir[grant_idx], grant_idx};
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with DEBOUNCE_CYCLES=4, FIFO_DEPTH=8.
module tb_key_event_ctrl;
  logic        clk = 1'b0;
  logic        reset_n, read, write, irq;
  logic [1:0]  address;
  logic [31:0] writedata, readdata;
  logic [3:0]  in_port;
  int tests = 0;
  int fails = 0;

  key_event_ctrl #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read),
    .write(write), .writedata(writedata), .readdata(readdata),
    .irq(irq), .in_port(in_port)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    tick(1);
    read = 1'b0;
    d    = readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    tick(1);
    write = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    tests++; if (readdata !== 32'h0) begin fails++; $display("FAIL reset_readdata: got %h want %h", readdata, 32'h0); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b want 0", irq); end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_reg%0d: got %h want %h", a, d, 32'h0); end
    end
  endtask

  task automatic test_debounce();
    logic [31:0] d, exp;
    in_port = 4'b1011;
    address = 2'd0;
    read    = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      exp = (i == 7) ? 32'h4 : 32'h0;
      tests++; if (readdata !== exp) begin fails++; $display("FAIL deb_timing c%0d: got %h want %h", i, readdata, exp); end
    end
    read = 1'b0;
    tick(3);
    rd(2'd1, d);
    tests++; if (d !== 32'h8000_0006) begin fails++; $display("FAIL deb_event: got %h want %h", d, 32'h8000_0006); end
    in_port = 4'hF;
    tick(10);
    rd(2'd3, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL deb_release_status: got %h want %h", d, 32'h0); end
    in_port = 4'b1011;
    tick(3);
    in_port = 4'hF;
    tick(10);
    rd(2'd3, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL glitch_status: got %h want %h", d, 32'h0); end
    rd(2'd0, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL glitch_state: got %h want %h", d, 32'h0); end
  endtask

  task automatic test_release();
    logic [31:0] d;
    in_port = 4'b1101; tick(10); in_port = 4'hF; tick(10);
    rd(2'd3, d);
    tests++; if (d !== 32'h1) begin fails++; $display("FAIL rel_off_level: got %h want %h", d, 32'h1); end
    rd(2'd1, d);
    tests++; if (d !== 32'h8000_0005) begin fails++; $display("FAIL rel_off_event: got %h want %h", d, 32'h8000_0005); end
    rd(2'd1, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL rel_off_empty: got %h want %h", d, 32'h0); end
    wr(2'd2, 32'h2);
    in_port = 4'b1101; tick(10); in_port = 4'hF; tick(10);
    rd(2'd3, d);
    tests++; if (d !== 32'h2) begin fails++; $display("FAIL rel_on_level: got %h want %h", d, 32'h2); end
    rd(2'd1, d);
    tests++; if (d !== 32'h8000_0005) begin fails++; $display("FAIL rel_on_press: got %h want %h", d, 32'h8000_0005); end
    rd(2'd1, d);
    tests++; if (d !== 32'h8000_0001) begin fails++; $display("FAIL rel_on_release: got %h want %h", d, 32'h8000_0001); end
    wr(2'd2, 32'h0);
  endtask

  task automatic test_arbitration();
    logic [31:0] d, exp;
    in_port = 4'h0;
    tick(10);
    rd(2'd3, d);
    tests++; if (d !== 32'h4) begin fails++; $display("FAIL arb_level: got %h want %h", d, 32'h4); end
    for (int k = 0; k < 4; k++) begin
      rd(2'd1, d);
      exp = 32'h8000_0004 + 32'(k);
      tests++; if (d !== exp) begin fails++; $display("FAIL arb_order%0d: got %h want %h", k, d, exp); end
    end
    in_port = 4'hF;
    tick(10);
    rd(2'd3, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL arb_drained: got %h want %h", d, 32'h0); end
  endtask

  task automatic fill_eight();
    for (int r = 0; r < 2; r++) begin
      in_port = 4'h0; tick(10); in_port = 4'hF; tick(10);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d, exp;
    fill_eight();
    rd(2'd3, d);
    tests++; if (d !== 32'h8) begin fails++; $display("FAIL ovf_full: got %h want %h", d, 32'h8); end
    in_port = 4'b1110;
    tick(10);
    rd(2'd3, d);
    tests++; if (d !== 32'h108) begin fails++; $display("FAIL ovf_set: got %h want %h", d, 32'h108); end
    wr(2'd3, 32'h0FF);
    rd(2'd3, d);
    tests++; if (d !== 32'h108) begin fails++; $display("FAIL ovf_other_bits: got %h want %h", d, 32'h108); end
    wr(2'd3, 32'h100);
    rd(2'd3, d);
    tests++; if (d !== 32'h8) begin fails++; $display("FAIL ovf_clear: got %h want %h", d, 32'h8); end
    for (int i = 0; i < 8; i++) begin
      rd(2'd1, d);
      exp = 32'h8000_0004 + 32'(i % 4);
      tests++; if (d !== exp) begin fails++; $display("FAIL ovf_drain%0d: got %h want %h", i, d, exp); end
    end
    rd(2'd1, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL ovf_lost9: got %h want %h", d, 32'h0); end
    in_port = 4'hF;
    tick(10);
  endtask

  task automatic test_push_pop();
    logic [31:0] d, exp;
    fill_eight();
    in_port = 4'b0111;
    tick(6);
    address = 2'd1;
    read    = 1'b1;
    tick(1);
    read = 1'b0;
    tests++; if (readdata !== 32'h8000_0004) begin fails++; $display("FAIL pp_pop: got %h want %h", readdata, 32'h8000_0004); end
    rd(2'd3, d);
    tests++; if (d !== 32'h8) begin fails++; $display("FAIL pp_status: got %h want %h", d, 32'h8); end
    for (int i = 0; i < 8; i++) begin
      rd(2'd1, d);
      exp = (i == 7) ? 32'h8000_0007 : 32'h8000_0004 + 32'((i + 1) % 4);
      tests++; if (d !== exp) begin fails++; $display("FAIL pp_drain%0d: got %h want %h", i, d, exp); end
    end
    in_port = 4'hF;
    tick(10);
  endtask

  task automatic test_irq_reset();
    logic [31:0] d;
    wr(2'd2, 32'h1);
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_empty: got %b want 0", irq); end
    in_port = 4'b1110;
    tick(10);
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_set: got %b want 1", irq); end
    rd(2'd1, d);
    tests++; if (d !== 32'h8000_0004) begin fails++; $display("FAIL irq_event: got %h want %h", d, 32'h8000_0004); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_pop: got %b want 0", irq); end
    in_port = 4'hF; tick(10);
    in_port = 4'b1101; tick(10);
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_set2: got %b want 1", irq); end
    rd(2'd2, d);
    tests++; if (d !== 32'h1) begin fails++; $display("FAIL irq_ctrl: got %h want %h", d, 32'h1); end
    in_port = 4'b1001;
    tick(3);
    #2 reset_n = 1'b0;
    #1;
    tests++; if (readdata !== 32'h0) begin fails++; $display("FAIL rst_readdata: got %h want %h", readdata, 32'h0); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL rst_irq: got %b want 0", irq); end
    tick(2);
    reset_n = 1'b1;
    rd(2'd3, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL rst_status: got %h want %h", d, 32'h0); end
    rd(2'd2, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL rst_ctrl: got %h want %h", d, 32'h0); end
    tick(10);
    rd(2'd3, d);
    tests++; if (d !== 32'h2) begin fails++; $display("FAIL held_level: got %h want %h", d, 32'h2); end
    rd(2'd1, d);
    tests++; if (d !== 32'h8000_0005) begin fails++; $display("FAIL held_key1: got %h want %h", d, 32'h8000_0005); end
    rd(2'd1, d);
    tests++; if (d !== 32'h8000_0006) begin fails++; $display("FAIL held_key2: got %h want %h", d, 32'h8000_0006); end
    in_port = 4'hF;
    tick(10);
  endtask

  initial begin
    reset_n   = 1'b0;
    read      = 1'b0;
    write     = 1'b0;
    address   = 2'd0;
    writedata = 32'h0;
    in_port   = 4'hF;
    tick(3);
    reset_n = 1'b1;
    test_reset();
    test_debounce();
    test_release();
    test_arbitration();
    test_overflow();
    test_push_pop();
    test_irq_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
